// File: rtl/neighbor_table_pkg.sv
// Shared types for the neighbor table controller.
//   nt_state_t    : controller states
//   upd_status_t  : result code reported with upd_done
//   nt_entry_t    : one neighbor table row (also the table's write layout)
package neighbor_table_pkg;

   localparam int NT_WORD_W = 16;
   localparam logic [NT_WORD_W-1:0] MY_NODE_ID_DEFAULT = 16'h000C;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITE,
      S_DROP,
      S_SCAN,
      S_CLEAR
   } nt_state_t;

   typedef enum logic [1:0] {
      UPD_NEW       = 2'b00,
      UPD_UPDATED   = 2'b01,
      UPD_DROP_SELF = 2'b10,
      UPD_DROP_FULL = 2'b11
   } upd_status_t;

   typedef struct packed {
      logic [NT_WORD_W-1:0] nodeID;
      logic [NT_WORD_W-1:0] hops;
      logic [NT_WORD_W-1:0] qvalue;
      logic [NT_WORD_W-1:0] energy;
      logic [NT_WORD_W-1:0] chhops;
   } nt_entry_t;

endpackage

// File: rtl/nt_free_slot_enc.sv
// Lowest-free-slot priority encoder over the occupancy bitmap.
//   valid    : per-slot occupancy
//   free_idx : lowest slot whose valid bit is clear (0 when full)
//   full     : every slot occupied
module nt_free_slot_enc #(
   parameter int NUM_ENTRIES = 32,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] valid,
   output logic [IDX_W-1:0]       free_idx,
   output logic                   full
);

   // Scan high to low so the last hit is the lowest free index.
   always_comb begin
      free_idx = '0;
      full     = 1'b1;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = IDX_W'(i);
            full     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/neighbor_table_ctrl.sv
// Neighbor table sequencing controller. Serialises QTU updates (lookup then
// in-place update or append) and best-Q scans over an external table with a
// combinational read port, and owns the per-slot valid bitmap.
//   clk, nrst            : clock, async active-low reset
//   HB_reset             : heartbeat reset, aborts any operation, clears occupancy
//   upd_*                : update request handshake, fields, done/status
//   scan_*, best_*       : scan request, busy/done, best-entry result
//   entry_count          : number of occupied slots
//   tbl_*                : table address, write strobe/data, read data
// WORD_WIDTH must match NT_WORD_W since captured fields use nt_entry_t.
module neighbor_table_ctrl
   import neighbor_table_pkg::*;
#(
   parameter int                    WORD_WIDTH  = 16,
   parameter int                    NUM_ENTRIES = 32,
   parameter logic [WORD_WIDTH-1:0] MY_NODE_ID  = MY_NODE_ID_DEFAULT,
   localparam int                   IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  HB_reset,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [WORD_WIDTH-1:0] upd_nodeID,
   input  logic [WORD_WIDTH-1:0] upd_hops,
   input  logic [WORD_WIDTH-1:0] upd_qvalue,
   input  logic [WORD_WIDTH-1:0] upd_energy,
   input  logic [WORD_WIDTH-1:0] upd_chhops,
   output logic                  upd_done,
   output logic [1:0]            upd_status,
   input  logic                  scan_req,
   output logic                  scan_busy,
   output logic                  scan_done,
   output logic                  best_found,
   output logic [IDX_W-1:0]      best_idx,
   output logic [WORD_WIDTH-1:0] best_nodeID,
   output logic [WORD_WIDTH-1:0] best_qvalue,
   output logic [IDX_W:0]        entry_count,
   output logic [IDX_W-1:0]      tbl_idx,
   output logic                  tbl_wr_en,
   output logic [WORD_WIDTH-1:0] tbl_nodeID,
   output logic [WORD_WIDTH-1:0] tbl_hops,
   output logic [WORD_WIDTH-1:0] tbl_qvalue,
   output logic [WORD_WIDTH-1:0] tbl_energy,
   output logic [WORD_WIDTH-1:0] tbl_chhops,
   input  logic [WORD_WIDTH-1:0] tbl_rd_nodeID,
   input  logic [WORD_WIDTH-1:0] tbl_rd_qvalue
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   nt_state_t              state;
   upd_status_t            status_q;
   nt_entry_t              cap;
   logic [NUM_ENTRIES-1:0] valid;
   logic [IDX_W-1:0]       idx;
   logic                   wr_q, done_q, scan_done_q;
   logic                   scan_fin;   // extra S_SCAN cycle that carries scan_done
   logic [IDX_W-1:0]       free_idx;
   logic                   full;

   nt_free_slot_enc #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_free (
      .valid    (valid),
      .free_idx (free_idx),
      .full     (full)
   );

   assign upd_ready  = (state == S_IDLE) && !HB_reset;
   assign scan_busy  = (state == S_SCAN);
   // Strobes are masked by HB_reset so an abort in the final cycle has no effect.
   assign tbl_wr_en  = wr_q && !HB_reset;
   assign upd_done   = done_q && !HB_reset;
   assign scan_done  = scan_done_q && !HB_reset;
   assign upd_status = status_q;
   assign tbl_idx    = idx;
   assign tbl_nodeID = cap.nodeID;
   assign tbl_hops   = cap.hops;
   assign tbl_qvalue = cap.qvalue;
   assign tbl_energy = cap.energy;
   assign tbl_chhops = cap.chhops;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= S_IDLE;
         status_q    <= UPD_NEW;
         cap         <= '0;
         valid       <= '0;
         idx         <= '0;
         wr_q        <= 1'b0;
         done_q      <= 1'b0;
         scan_done_q <= 1'b0;
         scan_fin    <= 1'b0;
         entry_count <= '0;
         best_found  <= 1'b0;
         best_idx    <= '0;
         best_nodeID <= '0;
         best_qvalue <= '0;
      end else if (HB_reset) begin
         state       <= S_CLEAR;
         valid       <= '0;
         entry_count <= '0;
         idx         <= '0;
         wr_q        <= 1'b0;
         done_q      <= 1'b0;
         scan_done_q <= 1'b0;
         scan_fin    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (upd_valid) begin
                  cap <= '{nodeID: upd_nodeID, hops: upd_hops, qvalue: upd_qvalue,
                           energy: upd_energy, chhops: upd_chhops};
                  if (upd_nodeID == MY_NODE_ID) begin
                     state    <= S_DROP;
                     status_q <= UPD_DROP_SELF;
                     done_q   <= 1'b1;
                  end else begin
                     state <= S_LOOKUP;
                     idx   <= '0;
                  end
               end else if (scan_req) begin
                  state       <= S_SCAN;
                  idx         <= '0;
                  best_found  <= 1'b0;
                  best_idx    <= '0;
                  best_nodeID <= '0;
                  best_qvalue <= '0;
               end
            end
            S_LOOKUP: begin
               if (valid[idx] && (tbl_rd_nodeID == cap.nodeID)) begin
                  state    <= S_WRITE;   // idx already points at the match
                  status_q <= UPD_UPDATED;
                  wr_q     <= 1'b1;
                  done_q   <= 1'b1;
               end else if (idx == LAST_IDX) begin
                  if (full) begin
                     state    <= S_DROP;
                     status_q <= UPD_DROP_FULL;
                     idx      <= '0;
                     done_q   <= 1'b1;
                  end else begin
                     state    <= S_WRITE;
                     status_q <= UPD_NEW;
                     idx      <= free_idx;
                     wr_q     <= 1'b1;
                     done_q   <= 1'b1;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_WRITE: begin
               valid[idx] <= 1'b1;
               if (status_q == UPD_NEW)
                  entry_count <= entry_count + 1'b1;
               wr_q   <= 1'b0;
               done_q <= 1'b0;
               idx    <= '0;
               state  <= S_IDLE;
            end
            S_DROP: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
            S_SCAN: begin
               if (scan_fin) begin
                  scan_fin    <= 1'b0;
                  scan_done_q <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  // Strict greater-than keeps the lower index on ties.
                  if (valid[idx] && (!best_found || (tbl_rd_qvalue > best_qvalue))) begin
                     best_found  <= 1'b1;
                     best_idx    <= idx;
                     best_nodeID <= tbl_rd_nodeID;
                     best_qvalue <= tbl_rd_qvalue;
                  end
                  if (idx == LAST_IDX) begin
                     scan_fin    <= 1'b1;
                     scan_done_q <= 1'b1;
                     idx         <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               valid       <= '0;
               entry_count <= '0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
module tb_neighbor_table_ctrl;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        HB_reset = 1'b0;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [15:0] upd_nodeID = '0, upd_hops = '0, upd_qvalue = '0, upd_energy = '0, upd_chhops = '0;
   logic        upd_done;
   logic [1:0]  upd_status;
   logic        scan_req = 1'b0;
   logic        scan_busy, scan_done, best_found;
   logic [4:0]  best_idx;
   logic [15:0] best_nodeID, best_qvalue;
   logic [5:0]  entry_count;
   logic [4:0]  tbl_idx;
   logic        tbl_wr_en;
   logic [15:0] tbl_nodeID, tbl_hops, tbl_qvalue, tbl_energy, tbl_chhops;
   logic [15:0] tbl_rd_nodeID, tbl_rd_qvalue;

   logic [15:0] mem_node [32];
   logic [15:0] mem_q    [32];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   neighbor_table_ctrl dut (
      .clk(clk), .nrst(nrst), .HB_reset(HB_reset),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_nodeID(upd_nodeID), .upd_hops(upd_hops), .upd_qvalue(upd_qvalue),
      .upd_energy(upd_energy), .upd_chhops(upd_chhops),
      .upd_done(upd_done), .upd_status(upd_status),
      .scan_req(scan_req), .scan_busy(scan_busy), .scan_done(scan_done),
      .best_found(best_found), .best_idx(best_idx),
      .best_nodeID(best_nodeID), .best_qvalue(best_qvalue),
      .entry_count(entry_count),
      .tbl_idx(tbl_idx), .tbl_wr_en(tbl_wr_en),
      .tbl_nodeID(tbl_nodeID), .tbl_hops(tbl_hops), .tbl_qvalue(tbl_qvalue),
      .tbl_energy(tbl_energy), .tbl_chhops(tbl_chhops),
      .tbl_rd_nodeID(tbl_rd_nodeID), .tbl_rd_qvalue(tbl_rd_qvalue)
   );

   // Table storage with a combinational read port.
   assign tbl_rd_nodeID = mem_node[tbl_idx];
   assign tbl_rd_qvalue = mem_q[tbl_idx];
   always @(posedge clk) begin
      if (tbl_wr_en) begin
         mem_node[tbl_idx] <= tbl_nodeID;
         mem_q[tbl_idx]    <= tbl_qvalue;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one update; report status, latency from accept, and write info at upd_done.
   task automatic do_upd(input logic [15:0] id, input logic [15:0] q,
                         output logic [1:0] st, output int lat, output logic wr,
                         output logic [4:0] widx, output logic [15:0] wnode,
                         output logic [15:0] wq);
      int w;
      @(negedge clk);
      w = 0;
      while (!upd_ready && w < 100) begin @(negedge clk); w++; end
      upd_valid = 1'b1; upd_nodeID = id; upd_qvalue = q;
      upd_hops = id ^ 16'h00FF; upd_energy = q + 16'd7; upd_chhops = 16'd3;
      @(posedge clk); #1 upd_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!upd_done && lat < 100);
      if (!upd_done) lat = 999;
      st = upd_status; wr = tbl_wr_en; widx = tbl_idx; wnode = tbl_nodeID; wq = tbl_qvalue;
   endtask

   task automatic do_scan(output int lat, output logic busy1, output logic rdy1);
      @(negedge clk);
      scan_req = 1'b1;
      @(posedge clk); #1 scan_req = 1'b0;
      lat = 0; busy1 = 1'b0; rdy1 = 1'b1;
      do begin
         @(negedge clk); lat++;
         if (lat == 1) begin busy1 = scan_busy; rdy1 = upd_ready; end
      end while (!scan_done && lat < 100);
      if (!scan_done) lat = 999;
   endtask

   initial begin
      logic [1:0]  st;
      int          lat, bad, hits;
      logic        wr, busy1, rdy1;
      logic [4:0]  widx;
      logic [15:0] wnode, wq;

      for (int i = 0; i < 32; i++) begin mem_node[i] = '0; mem_q[i] = '0; end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", upd_ready, 1);
      chk("rst_outs", {upd_done, scan_done, scan_busy, tbl_wr_en, best_found}, 0);
      chk("rst_count", entry_count, 0);
      chk("rst_idx", tbl_idx, 0);
      nrst = 1'b1;
      @(negedge clk);

      // Three appends
      do_upd(16'd1, 16'h10, st, lat, wr, widx, wnode, wq);
      chk("new1_status", st, 0); chk("new1_lat", lat, 33); chk("new1_idx", {wr, widx}, {1'b1, 5'd0});
      do_upd(16'd2, 16'h20, st, lat, wr, widx, wnode, wq);
      chk("new2_status", st, 0); chk("new2_lat", lat, 33); chk("new2_idx", {wr, widx}, {1'b1, 5'd1});
      do_upd(16'd3, 16'h30, st, lat, wr, widx, wnode, wq);
      chk("new3_status", st, 0); chk("new3_lat", lat, 33); chk("new3_idx", {wr, widx}, {1'b1, 5'd2});
      @(negedge clk);
      chk("count3", entry_count, 3);

      // In-place update of ID 2 (slot 1)
      do_upd(16'd2, 16'h50, st, lat, wr, widx, wnode, wq);
      chk("upd2_status", st, 1); chk("upd2_lat", lat, 3); chk("upd2_idx", {wr, widx}, {1'b1, 5'd1});
      chk("upd2_data", {wnode, wq}, {16'd2, 16'h50});
      @(negedge clk);
      chk("upd2_count", entry_count, 3);

      // Self ID drop
      do_upd(16'h000C, 16'h77, st, lat, wr, widx, wnode, wq);
      chk("self_status", st, 2); chk("self_lat", lat, 1); chk("self_nowr", wr, 0);

      // ID 3 -> qvalue 0x50 (slot 2), tie with slot 1
      do_upd(16'd3, 16'h50, st, lat, wr, widx, wnode, wq);
      chk("upd3_status", st, 1); chk("upd3_lat", lat, 4);

      // Scan: slots 0x10, 0x50, 0x50 -> lower index wins the tie
      do_scan(lat, busy1, rdy1);
      chk("scan_lat", lat, 33);
      chk("scan_busy_ready", {busy1, rdy1}, 2'b10);
      chk("scan_found", best_found, 1);
      chk("scan_idx", best_idx, 1);
      chk("scan_best", {best_nodeID, best_qvalue}, {16'd2, 16'h50});

      // HB_reset at C+10 of a lookup aborts the update
      @(negedge clk);
      upd_valid = 1'b1; upd_nodeID = 16'd7; upd_qvalue = 16'h70;
      @(posedge clk); #1 upd_valid = 1'b0;
      repeat (10) @(negedge clk);
      HB_reset = 1'b1;
      #1 chk("hb_ready_low", upd_ready, 0);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         HB_reset = 1'b0;
         if (upd_done || tbl_wr_en) hits++;
      end
      chk("hb_no_done", hits, 0);
      chk("hb_count", entry_count, 0);
      chk("hb_ready", upd_ready, 1);

      // Empty-table scan clears previous result
      do_scan(lat, busy1, rdy1);
      chk("empty_lat", lat, 33);
      chk("empty_found", best_found, 0);
      chk("empty_best", {best_idx, best_nodeID, best_qvalue}, 0);

      // Stale ID 3 in slot 2 is masked -> appended at slot 0
      do_upd(16'd3, 16'h33, st, lat, wr, widx, wnode, wq);
      chk("post_hb_status", st, 0); chk("post_hb_lat", lat, 33);
      chk("post_hb_idx", {wr, widx}, {1'b1, 5'd0});

      // Fill remaining 31 slots
      bad = 0;
      for (int i = 1; i < 32; i++) begin
         do_upd(16'h0100 + 16'(i), 16'(i), st, lat, wr, widx, wnode, wq);
         if (st != 2'b00 || widx != 5'(i) || lat != 33) bad++;
      end
      chk("fill_all_new", bad, 0);
      @(negedge clk);
      chk("fill_count", entry_count, 32);

      // Full table: new ID dropped, existing last-slot ID still updates
      do_upd(16'h0099, 16'h99, st, lat, wr, widx, wnode, wq);
      chk("full_status", st, 3); chk("full_lat", lat, 33); chk("full_nowr", wr, 0);
      do_upd(16'h011F, 16'hAA, st, lat, wr, widx, wnode, wq);
      chk("last_status", st, 1); chk("last_lat", lat, 33); chk("last_idx", {wr, widx}, {1'b1, 5'd31});
      @(negedge clk);
      chk("full_count", entry_count, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
